// File: rtl/bus_sram_bridge_if.sv
// Bus transaction and SRAM port bundles for the bus-to-SRAM bridge.
// The command encoding is shared through a small package.
package bus_sram_pkg;
  typedef enum logic {
    BUS_READ  = 1'b0,
    BUS_WRITE = 1'b1
  } bus_cmd_t;
endpackage

interface bus_trans_if_t #(
  parameter int AW = 32,
  parameter int DW = 32
);
  import bus_sram_pkg::*;

  typedef struct packed {
    bus_cmd_t          cmd;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     data;
    logic [DW/8-1:0]   strb;
  } req_pkt_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          ok;
  } rsp_pkt_t;

  logic     req_vld;
  logic     req_rdy;
  req_pkt_t req_pkt;
  logic     rsp_vld;
  logic     rsp_rdy;
  rsp_pkt_t rsp_pkt;

  modport slave (
    input  req_vld, req_pkt, rsp_rdy,
    output req_rdy, rsp_vld, rsp_pkt
  );

  modport master (
    output req_vld, req_pkt, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_pkt
  );
endinterface

interface sram_if_t #(
  parameter int SAW = 15,
  parameter int DW  = 32
);
  logic [SAW-1:0] addr;
  logic           wen;
  logic [DW-1:0]  wdata;
  logic [DW-1:0]  rdata;

  modport master (
    output addr, wen, wdata,
    input  rdata
  );

  modport slave (
    input  addr, wen, wdata,
    output rdata
  );
endinterface

// File: rtl/bus_sram_bridge.sv
// Bridges one-outstanding bus transactions onto a single-port SRAM.
// Partial-strobe writes are done as read-modify-write.
module bus_sram_bridge #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int SAW = 15
) (
  input logic         clk,
  input logic         rst_n,
  bus_trans_if_t.slave bus_if,
  sram_if_t.master    sram_if
);
  import bus_sram_pkg::*;

  localparam int SW = DW / 8;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    MERGE,
    RSP
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [SAW-1:0]  addr_q;
  logic [SAW-1:0]  addr_d;
  logic [DW-1:0]   data_q;
  logic [DW-1:0]   data_d;
  logic [SW-1:0]   strb_q;
  logic [SW-1:0]   strb_d;
  logic [DW-1:0]   rsp_data_q;
  logic [DW-1:0]   rsp_data_d;
  logic            rsp_ok_q;
  logic            rsp_ok_d;

  logic [AW-1:0]   req_addr;
  logic [SAW-1:0]  waddr;
  logic            in_range;
  logic            is_wr;
  logic            strb_all;
  logic            strb_none;
  logic            acc;
  logic            err;
  logic            rd_ok;
  logic            wr_full;
  logic            wr_none;
  logic            wr_part;
  logic [DW-1:0]   merged;

  logic            req_rdy;
  logic            rsp_vld;
  logic [SAW-1:0]  sram_addr;
  logic            sram_wen;
  logic [DW-1:0]   sram_wdata;

  assign req_addr  = bus_if.req_pkt.addr;
  assign waddr     = req_addr[SAW+1:2];
  assign in_range  = (req_addr[1:0] == 2'b00) &&
                     ((req_addr >> (SAW + 2)) == '0);
  assign is_wr     = (bus_if.req_pkt.cmd == BUS_WRITE);
  assign strb_all  = &bus_if.req_pkt.strb;
  assign strb_none = ~|bus_if.req_pkt.strb;
  assign acc       = rst_n && (state == IDLE) && bus_if.req_vld;

  assign err     = !in_range;
  assign rd_ok   = in_range && !is_wr;
  assign wr_full = in_range && is_wr && strb_all;
  assign wr_none = in_range && is_wr && strb_none;
  assign wr_part = in_range && is_wr && !strb_all && !strb_none;

  // Byte merge of held write data over the word read back from SRAM
  always_comb begin
    merged = '0;
    for (int i = 0; i < SW; i++) begin
      merged[i*8 +: 8] = strb_q[i] ? data_q[i*8 +: 8]
                                   : sram_if.rdata[i*8 +: 8];
    end
  end

  // Next-state, register loads and SRAM/bus outputs
  always_comb begin
    state_d    = state;
    addr_d     = addr_q;
    data_d     = data_q;
    strb_d     = strb_q;
    rsp_data_d = rsp_data_q;
    rsp_ok_d   = rsp_ok_q;
    req_rdy    = 1'b0;
    rsp_vld    = 1'b0;
    sram_addr  = addr_q;
    sram_wen   = 1'b0;
    sram_wdata = '0;
    unique case (state)
      IDLE: begin
        req_rdy   = rst_n;
        sram_addr = waddr;
        if (acc) begin
          addr_d     = waddr;
          data_d     = bus_if.req_pkt.data;
          strb_d     = bus_if.req_pkt.strb;
          rsp_data_d = '0;
          rsp_ok_d   = 1'b1;
          unique case (1'b1)
            err: begin
              rsp_ok_d = 1'b0;
              state_d  = RSP;
            end
            rd_ok: state_d = RD;
            wr_full: begin
              sram_wen   = 1'b1;
              sram_wdata = bus_if.req_pkt.data;
              state_d    = RSP;
            end
            wr_none: state_d = RSP;
            wr_part: state_d = MERGE;
            default: state_d = IDLE;
          endcase
        end
      end
      RD: begin
        rsp_data_d = sram_if.rdata;
        rsp_ok_d   = 1'b1;
        state_d    = RSP;
      end
      MERGE: begin
        sram_wen   = rst_n;
        sram_wdata = rst_n ? merged : '0;
        rsp_data_d = '0;
        rsp_ok_d   = 1'b1;
        state_d    = RSP;
      end
      RSP: begin
        rsp_vld = rst_n;
        if (bus_if.rsp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      rsp_data_q <= '0;
      rsp_ok_q   <= 1'b0;
    end else begin
      state      <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
      rsp_data_q <= rsp_data_d;
      rsp_ok_q   <= rsp_ok_d;
    end
  end

  assign bus_if.req_rdy   = req_rdy;
  assign bus_if.rsp_vld   = rsp_vld;
  assign bus_if.rsp_pkt   = {rsp_data_q, rsp_ok_q};
  assign sram_if.addr     = sram_addr;
  assign sram_if.wen      = sram_wen;
  assign sram_if.wdata    = sram_wdata;

endmodule

// File: doc/bus_sram_bridge.md
BUS_SRAM_BRIDGE -- requirements
Module: bus_sram_bridge

Interface
REQ-001 SHALL have parameter AW, default 32, bus byte-address width.
REQ-002 SHALL have parameter DW, default 32, data width; DW/8 strobe bits.
REQ-003 SHALL have parameter SAW, default 15, SRAM word-address width.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port bus_if, bus_trans_if_t.slave, AW/DW, request/response transaction port.
REQ-007 SHALL have port sram_if, sram_if_t.master, SAW/DW, single-port SRAM with 1-cycle synchronous read.

Function
REQ-008 SHALL decode word address as req_pkt.addr[SAW+1:2].
REQ-009 SHALL treat a request as in range only if addr[1:0]==0 and addr[AW-1:SAW+2]==0.
REQ-010 SHALL use states IDLE, RD, MERGE and RSP.
REQ-011 SHALL drive req_rdy=1 only in IDLE with rst_n high; a request is accepted in a cycle where req_vld&&req_rdy.
REQ-012 SHALL, in IDLE, drive sram_if.addr combinationally from req_pkt.addr and drive sram_if.wen=0 except as in REQ-014.
REQ-013 SHALL handle an accepted in-range BUS_READ: SRAM read in accept cycle T -> RD at T+1 capturing rdata -> RSP with rsp_vld from T+2, rsp_pkt.data=rdata, ok=1.
REQ-014 SHALL handle an accepted in-range BUS_WRITE with strobe all ones: wen=1, wdata=req_pkt.data in accept cycle -> RSP at T+1, data=0, ok=1.
REQ-015 SHALL handle an accepted in-range BUS_WRITE with partial nonzero strobe as read-modify-write:
- T: read issued at same address; req data and strobe registered.
- T+1 MERGE: wen=1, addr held; wdata byte i = strobe[i] ? req byte i : rdata byte i.
- T+2 RSP: data=0, ok=1.
REQ-016 SHALL treat an in-range BUS_WRITE with strobe==0 as a no-op: no SRAM write, RSP at T+1, ok=1, data=0.
REQ-017 SHALL answer an out-of-range or misaligned request of either command with no SRAM write, RSP at T+1, ok=0, data=0.
REQ-018 SHALL hold rsp_vld and rsp_pkt stable in RSP until rsp_rdy, then go to IDLE the next cycle; req_rdy=0 throughout RSP (one outstanding transaction).
REQ-019 SHALL assert wen in only two cases: a REQ-014 accept cycle and the MERGE state; wdata=0 whenever wen=0.
REQ-020 SHALL not treat a request from a prior cycle held with req_vld=0 as accepted; sram_if.addr is don't-care when wen=0 and no read is pending.
REQ-021 SHALL keep rsp_pkt.data 0 for every write and error response.

Reset
REQ-022 SHALL, while rst_n==0 at a rising edge, force: state=IDLE, rsp_vld=0, rsp_pkt=0, internal registers cleared.
REQ-023 SHALL hold combinationally while rst_n==0: req_rdy=0, wen=0, wdata=0.
REQ-024 SHALL abort any transaction when reset asserts mid-operation, including MERGE: no SRAM write occurs in a cycle with rst_n==0, and no response is issued for an aborted transaction.
REQ-025 SHALL accept a request in the first cycle with rst_n==1.

Verification
REQ-026 SHALL verify full write then read: write addr 0x10, data 0xDEADBEEF, strobe 0xF -> wen at T, rsp T+1 ok=1; read 0x10 -> rsp two cycles after accept, data 0xDEADBEEF, ok=1.
REQ-027 SHALL verify partial write: word 0x10 = 0xDEADBEEF; write data 0x00001234, strobe 0x3 -> MERGE wdata 0xDEAD1234; later read returns 0xDEAD1234.
REQ-028 SHALL verify errors:
- Read 0x00020000 (SAW=15) -> ok=0, data=0, wen never asserted.
- Write 0x12 -> ok=0, memory unchanged.
REQ-029 SHALL verify backpressure: rsp_rdy low 5 cycles during a read response -> rsp_vld and data stable, req_rdy=0; rsp_rdy high -> IDLE next cycle, req_rdy=1.
REQ-030 SHALL verify reset in MERGE of a strobe 0x1 write to 0x20 -> no write (word keeps old value), rsp_vld=0, req_rdy=1 first cycle after reset release.
REQ-031 SHALL verify strobe==0 write to 0x30 -> no wen, ok=1 at T+1, word unchanged.
